// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: 2-cycle multiplies, 32-iteration restoring divide.
// Define MULDIV_DIV_BYPASS_EN to complete divide-by-zero / signed-overflow requests in one cycle.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  typedef enum logic [4:0] {
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHU  = 5'd12,
    OP_MULHSU = 5'd13,
    OP_DIVU   = 5'd14,
    OP_REMU   = 5'd15,
    OP_DIV    = 5'd16,
    OP_REM    = 5'd17
  } op_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_next;
  op_t             op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
  logic [4:0]      cnt_q;
  logic            neg_quo_q, neg_rem_q, zero_q, ovf_q;

  logic            op_valid, is_div_in, signed_div_in, is_rem_in;
  logic            b_zero_in, ovf_in, accept, bypass;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_in;

  assign op_valid      = (op >= OP_MUL) && (op <= OP_REM);
  assign is_div_in     = (op >= OP_DIVU);
  assign signed_div_in = (op == OP_DIV) || (op == OP_REM);
  assign is_rem_in     = (op == OP_REMU) || (op == OP_REM);
  assign b_zero_in     = (operand_b == '0);
  assign ovf_in        = signed_div_in && (operand_a == INT_MIN) && (operand_b == '1);
  assign a_mag_in      = (signed_div_in && operand_a[XLEN-1]) ? (~operand_a + 1'b1) : operand_a;
  assign b_mag_in      = (signed_div_in && operand_b[XLEN-1]) ? (~operand_b + 1'b1) : operand_b;

  assign accept = start && op_valid && !flush && ((state == S_IDLE) || (state == S_DONE));

`ifdef MULDIV_DIV_BYPASS_EN
  assign bypass = is_div_in && (b_zero_in || ovf_in);
`else
  assign bypass = 1'b0;
`endif

  // Divide-by-zero dominates: with divisor 0 the overflow pattern cannot match anyway.
  function automatic logic [XLEN-1:0] special_result(input logic is_rem, input logic zero,
                                                     input logic [XLEN-1:0] dividend);
    if (zero) special_result = is_rem ? dividend : '1;
    else      special_result = is_rem ? '0 : INT_MIN;
  endfunction

  assign special_in = special_result(is_rem_in, b_zero_in, operand_a);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (!is_div_in)  state_next = S_MUL;
          else if (bypass) state_next = S_DONE;
          else             state_next = S_DIV;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_MUL:   state_next = S_DONE;
      S_DIV:   if (cnt_q == 5'd31) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  logic            a_sext, b_sext;
  logic [2*XLEN-1:0] a_ext, b_ext, product;
  logic [XLEN-1:0] mul_result;

  always_comb begin
    a_sext     = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1];
    b_sext     = (op_q == OP_MULH) && b_q[XLEN-1];
    a_ext      = {{XLEN{a_sext}}, a_q};
    b_ext      = {{XLEN{b_sext}}, b_q};
    product    = a_ext * b_ext;
    mul_result = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] quo_next, rem_next;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  logic            is_rem_q;
  logic [XLEN-1:0] fix_result;

  always_comb begin
    is_rem_q = (op_q == OP_REMU) || (op_q == OP_REM);
    if (zero_q || ovf_q)
      fix_result = special_result(is_rem_q, zero_q, a_q);
    else if (is_rem_q)
      fix_result = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    else
      fix_result = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  end

  // NOTE: the whole datapath is reset, not only result, so post-reset behaviour is deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result    <= '0;
    end else if (accept) begin
      op_q      <= op_t'(op);
      a_q       <= operand_a;
      b_q       <= operand_b;
      quo_q     <= a_mag_in;
      rem_q     <= '0;
      dvsr_q    <= b_mag_in;
      cnt_q     <= '0;
      neg_quo_q <= signed_div_in && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
      neg_rem_q <= signed_div_in && operand_a[XLEN-1];
      zero_q    <= b_zero_in;
      ovf_q     <= ovf_in;
      if (bypass) result <= special_in;
    end else begin
      unique case (state)
        S_MUL: if (!flush) result <= mul_result;
        S_DIV: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + 5'd1;
        end
        S_FIX: if (!flush) result <= fix_result;
        default: ;
      endcase
    end
  end

  assign busy  = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done  = (state == S_DONE);
  assign stall = accept || busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; expected latencies follow MULDIV_DIV_BYPASS_EN.
module tb_muldiv_seq;

  logic        clk, rst, start, flush;
  logic [4:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        stall, busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_exp = 32'h0;

`ifdef MULDIV_DIV_BYPASS_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHU = 5'd12, MULHSU = 5'd13;
  localparam logic [4:0] DIVU = 5'd14, REMU = 5'd15, DIV = 5'd16, REM = 5'd17;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1 of cycle N; returns at posedge+1 of cycle N+1 with stall seen in N.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic st);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    st = stall;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded); returns at posedge+1 of the cycle after done.
  task automatic wait_done(output int lat, output int stall_hi, output logic [31:0] res,
                           output logic ok, output logic st_done, output logic done_after);
    lat = 0; stall_hi = 0; res = 'x; ok = 1'b0; st_done = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; res = result; ok = 1'b1; st_done = stall;
        break;
      end
      if (stall) stall_hi++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b stall=%b result=%h, want 0 0 0 00000000",
               busy, done, stall, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_table(input string tag, input vec_t tbl[]);
    logic st_n, ok, st_done, done_after;
    int lat, stall_hi;
    logic [31:0] res;
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, st_n);
      wait_done(lat, stall_hi, res, ok, st_done, done_after);
      last_exp = tbl[i].exp;
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL %s[%0d] timeout: no done within 60 cycles", tag, i);
        continue;
      end
      vectors++;
      if (res !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL %s[%0d] result: got %h want %h", tag, i, res, tbl[i].exp);
      end
      vectors++;
      if (lat != tbl[i].lat) begin
        miscompares++;
        $display("FAIL %s[%0d] latency: got %0d want %0d", tag, i, lat, tbl[i].lat);
      end
      vectors++;
      if (st_n !== 1'b1 || stall_hi != lat - 1 || st_done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s[%0d] stall: N=%b busy_cycles=%0d at_done=%b, want 1 %0d 0",
                 tag, i, st_n, stall_hi, st_done, lat - 1);
      end
      vectors++;
      if (done_after !== 1'b0) begin
        miscompares++;
        $display("FAIL %s[%0d] done_pulse: done after=%b want 0", tag, i, done_after);
      end
    end
  endtask

  task automatic test_mul();
    vec_t t[];
    t = new[6];
    t[0] = '{MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2};
    t[1] = '{MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 2};
    t[2] = '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2};
    t[3] = '{MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 2};
    t[4] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2};
    t[5] = '{MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 2};
    test_table("mul", t);
  endtask

  task automatic test_div();
    vec_t t[];
    t = new[6];
    t[0] = '{DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
    t[1] = '{REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
    t[2] = '{DIVU, 32'd100,      32'd7,        32'd14,       34};
    t[3] = '{REMU, 32'd100,      32'd7,        32'd2,        34};
    t[4] = '{DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    t[5] = '{REM,  32'd7,        32'hFFFFFFFE, 32'd1,        34};
    test_table("div", t);
  endtask

  task automatic test_special();
    vec_t t[];
    t = new[6];
    t[0] = '{DIVU, 32'd100,      32'h00000000, 32'hFFFFFFFF, SPECIAL_LAT};
    t[1] = '{REMU, 32'd100,      32'h00000000, 32'd100,      SPECIAL_LAT};
    t[2] = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT};
    t[3] = '{REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPECIAL_LAT};
    t[4] = '{DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, SPECIAL_LAT};
    t[5] = '{REM,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, SPECIAL_LAT};
    test_table("special", t);
  endtask

  task automatic test_flush();
    logic st_n;
    int seen_done;
    issue(DIVU, 32'd1000, 32'd3, st_n);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_cycle_stall: got %b want 1", stall);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result !== last_exp) begin
      miscompares++;
      $display("FAIL flush_after: stall=%b busy=%b done=%b result=%h, want 0 0 0 %h",
               stall, busy, done, result, last_exp);
    end
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    vectors++;
    if (seen_done != 0) begin
      miscompares++;
      $display("FAIL flush_no_done: done seen %0d times want 0", seen_done);
    end
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = DIV; operand_a = 32'd9; operand_b = 32'd2;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_beats_start_stall: got %b want 0", stall);
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_beats_start_state: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic st_n;
    int k;
    issue(DIVU, 32'd10, 32'd3, st_n);
    k = 1;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    vectors++;
    if (done !== 1'b1 || k != 34 || result !== 32'd3) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b cycle=%0d result=%h, want 1 34 00000003", done, k, result);
    end
    start = 1'b1; op = MUL; operand_a = 32'd3; operand_b = 32'd5;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept_stall: got %b want 1", stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_mul_busy: done=%b busy=%b want 0 1", done, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || result !== 32'd15) begin
      miscompares++;
      $display("FAIL b2b_second: done=%b result=%h want 1 0000000f", done, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div();
    logic st_n;
    issue(DIV, 32'hFFFFFFF9, 32'd2, st_n);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_div: busy=%b stall=%b done=%b result=%h, want 0 0 0 00000000",
               busy, stall, done, result);
    end
    @(posedge clk); #1;
    start = 1'b1; op = 5'd5; operand_a = 32'd1; operand_b = 32'd1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_op_stall: got %b want 0", stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL bad_op_state: busy=%b done=%b result=%h want 0 0 00000000",
               busy, done, result);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
